// File: rtl/gba_bus_pkg.sv
// Shared types and constants for the CPU/DMA bus arbitration slice.
package gba_bus_pkg;

  typedef enum logic [1:0] {
    CPU,
    TO_DMA,
    DMA,
    TO_CPU
  } arb_state_t;

  localparam int unsigned MAX_DMA  = 4;
  localparam int unsigned DMA_CH_W = $clog2(MAX_DMA);

  // Debug owner encoding: dma=0 means the CPU owns the bus and ch is don't-care.
  typedef struct packed {
    logic                dma;
    logic [DMA_CH_W-1:0] ch;
  } bus_owner_t;

endpackage

// File: rtl/dma_prio_enc.sv
// Fixed-priority encoder; channel 0 wins. Only channels set in mask_i compete.
module dma_prio_enc #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  output logic         valid_o,
  output logic [W-1:0] index_o,
  output logic [N-1:0] onehot_o
);

  always_comb begin
    valid_o  = 1'b0;
    index_o  = '0;
    onehot_o = '0;
    // Scan downwards so the lowest-numbered eligible channel is the last writer.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i] && mask_i[i]) begin
        valid_o     = 1'b1;
        index_o     = W'(i);
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Hands the shared bus between the CPU and NUM_DMA DMA channels with idle turnaround
// cycles on every CPU<->DMA change and fixed-priority preemption at unit boundaries.
module dma_bus_arbiter
  import gba_bus_pkg::*;
#(
  parameter int unsigned NUM_DMA        = 4,
  parameter int unsigned HANDOFF_CYCLES = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_DMA-1:0] dma_req,
  input  logic [NUM_DMA-1:0] dma_unit_done,
  input  logic               cpu_lock,
  output logic [NUM_DMA-1:0] dma_grant,
  output logic               dmaActive,
  output logic               cpu_pause,
  output logic               bus_idle
);

  localparam int unsigned ChW  = (NUM_DMA > 1) ? $clog2(NUM_DMA) : 1;
  localparam int unsigned CntW = $clog2(HANDOFF_CYCLES + 1);

  arb_state_t         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [ChW-1:0]     owner_q, owner_d;
  logic [NUM_DMA-1:0] grant_q, grant_d;
  logic               active_q, pause_q, idle_q;

  logic [NUM_DMA-1:0] enc_mask;
  logic               enc_valid;
  logic [ChW-1:0]     enc_index;
  logic [NUM_DMA-1:0] enc_onehot;

  // While the owner still requests, only strictly higher channels may take over.
  always_comb begin
    enc_mask = '1;
    if (state_q == DMA && dma_req[owner_q]) begin
      enc_mask = (NUM_DMA'(1) << owner_q) - NUM_DMA'(1);
    end
  end

  dma_prio_enc #(
    .N (NUM_DMA),
    .W (ChW)
  ) u_prio_enc (
    .req_i    (dma_req),
    .mask_i   (enc_mask),
    .valid_o  (enc_valid),
    .index_o  (enc_index),
    .onehot_o (enc_onehot)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    grant_d = grant_q;
    unique case (state_q)
      CPU: begin
        if (|dma_req && !cpu_lock) begin
          state_d = TO_DMA;
          cnt_d   = CntW'(HANDOFF_CYCLES);
        end
      end
      TO_DMA: begin
        if (cnt_q > CntW'(1)) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (enc_valid) begin
          state_d = DMA;
          owner_d = enc_index;
          grant_d = enc_onehot;
        end else begin
          state_d = TO_CPU;
          cnt_d   = CntW'(HANDOFF_CYCLES);
        end
      end
      DMA: begin
        if (!dma_req[owner_q]) begin
          if (enc_valid) begin
            owner_d = enc_index;
            grant_d = enc_onehot;
          end else begin
            state_d = TO_CPU;
            cnt_d   = CntW'(HANDOFF_CYCLES);
            grant_d = '0;
          end
        end else if (dma_unit_done[owner_q] && enc_valid) begin
          owner_d = enc_index;
          grant_d = enc_onehot;
        end
      end
      TO_CPU: begin
        if (cnt_q > CntW'(1)) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (|dma_req) begin
          state_d = TO_DMA;
          cnt_d   = CntW'(HANDOFF_CYCLES);
        end else begin
          state_d = CPU;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= CPU;
      cnt_q    <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      active_q <= 1'b0;
      pause_q  <= 1'b0;
      idle_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      active_q <= (state_d == DMA);
      pause_q  <= (state_d != CPU);
      idle_q   <= (state_d == TO_DMA) || (state_d == TO_CPU);
    end
  end

  assign dma_grant = grant_q;
  assign dmaActive = active_q;
  assign cpu_pause = pause_q;
  assign bus_idle  = idle_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench: one DUT with one turnaround cycle, a second with three; shared stimulus.
module tb_dma_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] dma_req;
  logic [3:0] dma_unit_done;
  logic       cpu_lock;

  logic [3:0] grant1, grant3;
  logic       act1, pause1, idle1;
  logic       act3, pause3, idle3;

  int total = 0;
  int bad   = 0;
  logic inv_en = 1'b0;

  always #5 clock = ~clock;

  dma_bus_arbiter #(
    .NUM_DMA        (4),
    .HANDOFF_CYCLES (1)
  ) dut1 (
    .clock         (clock),
    .reset_n       (reset_n),
    .dma_req       (dma_req),
    .dma_unit_done (dma_unit_done),
    .cpu_lock      (cpu_lock),
    .dma_grant     (grant1),
    .dmaActive     (act1),
    .cpu_pause     (pause1),
    .bus_idle      (idle1)
  );

  dma_bus_arbiter #(
    .NUM_DMA        (4),
    .HANDOFF_CYCLES (3)
  ) dut3 (
    .clock         (clock),
    .reset_n       (reset_n),
    .dma_req       (dma_req),
    .dma_unit_done (dma_unit_done),
    .cpu_lock      (cpu_lock),
    .dma_grant     (grant3),
    .dmaActive     (act3),
    .cpu_pause     (pause3),
    .bus_idle      (idle3)
  );

  // Structural invariants on both instances, sampled mid-cycle.
  always @(negedge clock) begin
    if (inv_en) begin
      total++;
      if (!$onehot0(grant1) || act1 !== |grant1 || (act1 && idle1) || (!pause1 && act1) ||
          !$onehot0(grant3) || act3 !== |grant3 || (act3 && idle3) || (!pause3 && act3)) begin
        bad++;
        $display("FAIL invariant t=%0t: g1=%b a1=%b p1=%b i1=%b g3=%b a3=%b p3=%b i3=%b",
                 $time, grant1, act1, pause1, idle1, grant3, act3, pause3, idle3);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    dma_req       = '0;
    dma_unit_done = '0;
    cpu_lock      = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    inv_en = 1'b1;
    total++;
    if ({grant1, act1, pause1, idle1} !== 7'b0) begin
      bad++;
      $display("FAIL reset_h1: got %b want 0000000", {grant1, act1, pause1, idle1});
    end
    total++;
    if ({grant3, act3, pause3, idle3} !== 7'b0) begin
      bad++;
      $display("FAIL reset_h3: got %b want 0000000", {grant3, act3, pause3, idle3});
    end
  endtask

  task automatic test_turnaround();
    do_reset();
    dma_req = 4'b0100;
    tick();
    total++;
    if ({grant1, act1, pause1, idle1} !== 7'b0000_011) begin
      bad++;
      $display("FAIL turn_pause: got %b want 0000011", {grant1, act1, pause1, idle1});
    end
    tick();
    total++;
    if ({grant1, act1, pause1, idle1} !== 7'b0100_110) begin
      bad++;
      $display("FAIL turn_grant: got %b want 0100110", {grant1, act1, pause1, idle1});
    end
    repeat (3) tick();
    total++;
    if (grant1 !== 4'b0100) begin
      bad++;
      $display("FAIL turn_hold: got %b want 0100", grant1);
    end
    dma_req = 4'b0000;
    tick();
    total++;
    if ({grant1, act1, pause1, idle1} !== 7'b0000_011) begin
      bad++;
      $display("FAIL turn_release: got %b want 0000011", {grant1, act1, pause1, idle1});
    end
    tick();
    total++;
    if ({grant1, act1, pause1, idle1} !== 7'b0) begin
      bad++;
      $display("FAIL turn_cpu: got %b want 0000000", {grant1, act1, pause1, idle1});
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    dma_req = 4'b1010;
    tick();
    tick();
    total++;
    if (grant1 !== 4'b0010 || act1 !== 1'b1) begin
      bad++;
      $display("FAIL simul_first: got %b/%b want 0010/1", grant1, act1);
    end
    dma_req = 4'b1000;
    tick();
    total++;
    if (grant1 !== 4'b1000 || act1 !== 1'b1 || idle1 !== 1'b0) begin
      bad++;
      $display("FAIL simul_switch: got %b/%b/%b want 1000/1/0", grant1, act1, idle1);
    end
    dma_req = 4'b0000;
    tick();
    tick();
    total++;
    if (pause1 !== 1'b0) begin
      bad++;
      $display("FAIL simul_done: pause got %b want 0", pause1);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    dma_req = 4'b1000;
    tick();
    tick();
    dma_req = 4'b1001;
    tick();
    tick();
    total++;
    if (grant1 !== 4'b1000) begin
      bad++;
      $display("FAIL preempt_no_done: got %b want 1000", grant1);
    end
    dma_unit_done = 4'b0001;
    tick();
    dma_unit_done = 4'b0000;
    total++;
    if (grant1 !== 4'b1000) begin
      bad++;
      $display("FAIL preempt_foreign_done: got %b want 1000", grant1);
    end
    dma_unit_done = 4'b1000;
    tick();
    dma_unit_done = 4'b0000;
    total++;
    if (grant1 !== 4'b0001 || act1 !== 1'b1) begin
      bad++;
      $display("FAIL preempt_switch: got %b/%b want 0001/1", grant1, act1);
    end
    dma_req = 4'b1000;
    tick();
    total++;
    if (grant1 !== 4'b1000 || act1 !== 1'b1) begin
      bad++;
      $display("FAIL preempt_regrant: got %b/%b want 1000/1", grant1, act1);
    end
    dma_req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    cpu_lock = 1'b1;
    dma_req  = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (pause1 !== 1'b0) begin
        bad++;
        $display("FAIL lock_hold%0d: pause got %b want 0", i, pause1);
      end
    end
    cpu_lock = 1'b0;
    tick();
    total++;
    if (pause1 !== 1'b1 || idle1 !== 1'b1) begin
      bad++;
      $display("FAIL lock_drop: pause/idle got %b/%b want 1/1", pause1, idle1);
    end
    tick();
    total++;
    if (grant1 !== 4'b0001) begin
      bad++;
      $display("FAIL lock_grant: got %b want 0001", grant1);
    end
    dma_req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    dma_req = 4'b0010;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    total++;
    if ({grant1, act1, pause1, idle1} !== 7'b0) begin
      bad++;
      $display("FAIL reset_mid: got %b want 0000000", {grant1, act1, pause1, idle1});
    end
    reset_n = 1'b1;
    dma_req = 4'b0000;
    tick();
    total++;
    if (pause1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_after: pause got %b want 0", pause1);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    dma_req = 4'b0100;
    tick();
    tick();
    dma_req = 4'b0000;
    tick();
    dma_req = 4'b0100;
    tick();
    total++;
    if (pause1 !== 1'b1 || idle1 !== 1'b1 || grant1 !== 4'b0000) begin
      bad++;
      $display("FAIL bounce_turn: p/i/g got %b/%b/%b want 1/1/0000", pause1, idle1, grant1);
    end
    tick();
    total++;
    if (grant1 !== 4'b0100 || pause1 !== 1'b1) begin
      bad++;
      $display("FAIL bounce_regrant: g/p got %b/%b want 0100/1", grant1, pause1);
    end
    dma_req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_handoff3();
    do_reset();
    dma_req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (idle3 !== 1'b1 || pause3 !== 1'b1 || grant3 !== 4'b0000) begin
        bad++;
        $display("FAIL h3_in_idle%0d: i/p/g got %b/%b/%b want 1/1/0000", i, idle3, pause3, grant3);
      end
    end
    tick();
    total++;
    if (grant3 !== 4'b0100 || idle3 !== 1'b0) begin
      bad++;
      $display("FAIL h3_grant: g/i got %b/%b want 0100/0", grant3, idle3);
    end
    dma_req = 4'b0000;
    tick();
    dma_req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (idle3 !== 1'b1 || pause3 !== 1'b1 || grant3 !== 4'b0000) begin
        bad++;
        $display("FAIL h3_bounce%0d: i/p/g got %b/%b/%b want 1/1/0000", i, idle3, pause3, grant3);
      end
    end
    tick();
    total++;
    if (grant3 !== 4'b0100 || pause3 !== 1'b1) begin
      bad++;
      $display("FAIL h3_regrant: g/p got %b/%b want 0100/1", grant3, pause3);
    end
    dma_req = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (pause3 !== 1'b1) begin
      bad++;
      $display("FAIL h3_out_idle: pause got %b want 1", pause3);
    end
    tick();
    total++;
    if (pause3 !== 1'b0 || idle3 !== 1'b0) begin
      bad++;
      $display("FAIL h3_cpu: p/i got %b/%b want 0/0", pause3, idle3);
    end
  endtask

  initial begin
    test_reset();
    test_turnaround();
    test_simultaneous();
    test_preempt();
    test_lock();
    test_reset_mid();
    test_bounce();
    test_handoff3();
    inv_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
